reaction_timer: RTL and testbench

REACTION_TIMER -- requirements
Module: reaction_timer

---
 rtl/reaction_timer.sv | 191 +++++++++++++++++++
 tb/tb_reaction_timer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer.sv
// -----------------------------------------------------------------------------
// reaction_timer
//
// Measures a player's reaction time in milliseconds. The sequencing logic
// pulses start when a trial's light sequence begins and time_out when the
// lights go off. The player's button (react_trigger) is asynchronous, so it
// passes through a synchroniser and rising-edge detector. A press after
// lights-off completes the trial. A press before lights-off is a false start.
//
// Ports
//   clk            in   50 MHz board clock
//   reset          in   asynchronous, active-high reset
//   tick_ms        in   one-clk pulse once per millisecond
//   start          in   one-clk pulse: a new trial begins (goes to ARMED)
//   time_out       in   one-clk pulse: lights off, timing starts
//   react_trigger  in   player button, active high, asynchronous to clk
//   reaction_time  out  last measured reaction in ms (binary, 14 bits)
//   best_time      out  smallest non-saturated reaction since reset
//   valid          out  one-clk pulse when reaction_time is updated
//   false_start    out  level, high while in FALSE
//   overflow       out  level, high in DONE when the count saturated
//   busy           out  level, high in ARMED or TIMING
//   dbg_state      out  current FSM state, for observation only
//
// Handshake: there is no backpressure. Each control input (start, time_out,
// tick_ms) is a single-cycle event that is taken on the clock edge where it
// is high. valid is a single-cycle event. It is high for exactly one cycle,
// and reaction_time already holds the new value during that cycle.
//
// All outputs come straight from flip-flops.
// -----------------------------------------------------------------------------
module reaction_timer #(
    parameter int MAX_MS      = 9999,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_ms,
    input  logic        start,
    input  logic        time_out,
    input  logic        react_trigger,
    output logic [13:0] reaction_time,
    output logic [13:0] best_time,
    output logic        valid,
    output logic        false_start,
    output logic        overflow,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    // Reject parameter values the datapath cannot support.
    if (MAX_MS < 0 || MAX_MS > 16383) begin : g_bad_max_ms
        $error("reaction_timer: MAX_MS must fit in 14 bits");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("reaction_timer: SYNC_STAGES must be at least 2");
    end

    localparam logic [13:0] MaxCount = 14'(MAX_MS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_TIMING = 3'd2,
        S_DONE   = 3'd3,
        S_FALSE  = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Button synchroniser and press detection
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   prev_q;
    logic                   seen_low_q;
    logic                   btn_lvl;
    logic                   press_evt;

    assign btn_lvl = sync_q[SYNC_STAGES-1];

    // fill_q tracks how far real input samples have moved into the chain
    // since reset. Until the chain is full, btn_lvl still shows reset zeros.
    // seen_low_q is set only after the button has truly been released.
    // Because of this, a button that is held while reset is released does
    // not look like a fresh press. It must be released and pressed again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            fill_q     <= '0;
            prev_q     <= 1'b0;
            seen_low_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], react_trigger};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q <= btn_lvl;
            if (fill_q[SYNC_STAGES-1] && !btn_lvl) begin
                seen_low_q <= 1'b1;
            end
        end
    end

    assign press_evt = btn_lvl & ~prev_q & seen_low_q;

    // -------------------------------------------------------------------------
    // Trial FSM with registered outputs
    // -------------------------------------------------------------------------
    state_t      state_q;
    logic [13:0] count_q;
    logic [13:0] reaction_q;
    logic [13:0] best_q;
    logic        valid_q;
    logic        false_q;
    logic        ovf_q;
    logic        busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            reaction_q <= '0;
            best_q     <= MaxCount;
            valid_q    <= 1'b0;
            false_q    <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            // start overrides everything else and restarts from any state.
            // The previous results stay visible.
            if (start) begin
                state_q <= S_ARMED;
                count_q <= '0;
                ovf_q   <= 1'b0;
                false_q <= 1'b0;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    S_ARMED: begin
                        // A press wins over a time_out in the same cycle.
                        if (press_evt) begin
                            state_q <= S_FALSE;
                            false_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (time_out) begin
                            state_q <= S_TIMING;
                            count_q <= '0;
                        end
                    end
                    S_TIMING: begin
                        // A press wins over a tick in the same cycle. The
                        // count that was reached before the tick is kept.
                        if (press_evt) begin
                            state_q    <= S_DONE;
                            reaction_q <= count_q;
                            valid_q    <= 1'b1;
                            busy_q     <= 1'b0;
                            if (count_q < best_q) begin
                                best_q <= count_q;
                            end
                        end else if (tick_ms) begin
                            if (count_q == MaxCount) begin
                                // Saturated: report the limit. best_time is
                                // not updated from a saturated result.
                                state_q    <= S_DONE;
                                reaction_q <= MaxCount;
                                ovf_q      <= 1'b1;
                                valid_q    <= 1'b1;
                                busy_q     <= 1'b0;
                            end else begin
                                count_q <= count_q + 14'd1;
                            end
                        end
                    end
                    // IDLE, DONE and FALSE wait for start and ignore all
                    // other inputs.
                    default: begin
                    end
                endcase
            end
        end
    end

    assign reaction_time = reaction_q;
    assign best_time     = best_q;
    assign valid         = valid_q;
    assign false_start   = false_q;
    assign overflow      = ovf_q;
    assign busy          = busy_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_reaction_timer.sv
module tb_reaction_timer;

    localparam int MAX  = 9999;
    localparam int SYNC = 2;

    logic        clk;
    logic        reset;
    logic        tick_ms;
    logic        start;
    logic        time_out;
    logic        react_trigger;
    logic [13:0] reaction_time;
    logic [13:0] best_time;
    logic        valid;
    logic        false_start;
    logic        overflow;
    logic        busy;
    logic [2:0]  dbg_state;

    int checks = 0;
    int passes = 0;
    int valid_cnt = 0;

    // Reference model: the results the specification's rules predict.
    int m_reaction;
    int m_best;
    bit m_ovf;

    reaction_timer #(.MAX_MS(MAX), .SYNC_STAGES(SYNC)) dut (
        .clk           (clk),
        .reset         (reset),
        .tick_ms       (tick_ms),
        .start         (start),
        .time_out      (time_out),
        .react_trigger (react_trigger),
        .reaction_time (reaction_time),
        .best_time     (best_time),
        .valid         (valid),
        .false_start   (false_start),
        .overflow      (overflow),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Count every cycle in which valid is high, sampled away from the edge.
    always @(negedge clk) begin
        if (valid === 1'b1) valid_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic pulse_timeout();
        time_out = 1'b1; cyc(1); time_out = 1'b0;
    endtask

    task automatic send_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_ms = 1'b1; cyc(1);
            tick_ms = 1'b0; cyc(1);
        end
    endtask

    // Raise the button. The press reaches the FSM SYNC+1 edges later. The
    // optional tick/time_out pulses are placed on exactly that edge.
    task automatic do_press(input bit tick_on_act, input bit to_on_act);
        react_trigger = 1'b1;
        cyc(SYNC);
        tick_ms  = tick_on_act;
        time_out = to_on_act;
        cyc(1);
        tick_ms  = 1'b0;
        time_out = 1'b0;
    endtask

    task automatic release_btn();
        react_trigger = 1'b0;
        cyc(SYNC + 2);
    endtask

    // ---------------- scenarios ----------------
    task automatic finish_trial(input int ticks, input string tag);
        int v0;
        v0 = valid_cnt;
        pulse_timeout();
        cyc($urandom_range(0, 3));
        send_ticks(ticks);
        do_press(1'b0, 1'b0);
        release_btn();
        if (ticks > MAX) begin
            m_reaction = MAX;
            m_ovf = 1'b1;
        end else begin
            m_reaction = ticks;
            m_ovf = 1'b0;
            if (ticks < m_best) m_best = ticks;
        end
        checks++; if (reaction_time !== 14'(m_reaction)) $display("FAIL %s reaction_time: got %0d, expected %0d", tag, reaction_time, m_reaction); else passes++;
        checks++; if (best_time !== 14'(m_best)) $display("FAIL %s best_time: got %0d, expected %0d", tag, best_time, m_best); else passes++;
        checks++; if (overflow !== m_ovf) $display("FAIL %s overflow: got %0b, expected %0b", tag, overflow, m_ovf); else passes++;
        checks++; if (valid_cnt - v0 !== 1) $display("FAIL %s valid_pulses: got %0d, expected 1", tag, valid_cnt - v0); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL %s busy: got %0b, expected 0", tag, busy); else passes++;
        checks++; if (false_start !== 1'b0) $display("FAIL %s false_start: got %0b, expected 0", tag, false_start); else passes++;
    endtask

    task automatic run_trial(input int ticks, input string tag);
        pulse_start();
        checks++; if (busy !== 1'b1) $display("FAIL %s busy_armed: got %0b, expected 1", tag, busy); else passes++;
        cyc($urandom_range(1, 4));
        finish_trial(ticks, tag);
    endtask

    task automatic test_reset();
        reset = 1'b1; tick_ms = 0; start = 0; time_out = 0; react_trigger = 0;
        cyc(3);
        m_reaction = 0; m_best = MAX; m_ovf = 0;
        checks++; if (reaction_time !== 14'd0) $display("FAIL reset_reaction: got %0d, expected 0", reaction_time); else passes++;
        checks++; if (best_time !== 14'(MAX)) $display("FAIL reset_best: got %0d, expected %0d", best_time, MAX); else passes++;
        checks++; if ({valid, false_start, overflow, busy} !== 4'b0) $display("FAIL reset_flags: got %b, expected 0000", {valid, false_start, overflow, busy}); else passes++;
        reset = 1'b0;
        cyc(SYNC + 3);
    endtask

    task automatic test_idle_ignore();
        int v0;
        v0 = valid_cnt;
        pulse_timeout();
        send_ticks(3);
        do_press(1'b1, 1'b1);
        release_btn();
        checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %0b, expected 0", busy); else passes++;
        checks++; if (reaction_time !== 14'd0) $display("FAIL idle_reaction: got %0d, expected 0", reaction_time); else passes++;
        checks++; if (valid_cnt !== v0) $display("FAIL idle_valid: got %0d, expected %0d", valid_cnt, v0); else passes++;
        checks++; if (false_start !== 1'b0) $display("FAIL idle_false: got %0b, expected 0", false_start); else passes++;
    endtask

    task automatic test_normal();
        int v0;
        run_trial(237, "normal237");
        // DONE holds: inputs other than start are ignored.
        v0 = valid_cnt;
        pulse_timeout();
        send_ticks(4);
        do_press(1'b0, 1'b0);
        release_btn();
        checks++; if (reaction_time !== 14'd237) $display("FAIL done_hold_reaction: got %0d, expected 237", reaction_time); else passes++;
        checks++; if (valid_cnt !== v0) $display("FAIL done_hold_valid: got %0d, expected %0d", valid_cnt, v0); else passes++;
    endtask

    task automatic test_best();
        run_trial(412, "best412");
        run_trial(150, "best150");
    endtask

    task automatic test_false_start();
        int v0;
        v0 = valid_cnt;
        pulse_start();
        cyc(2);
        do_press(1'b0, 1'b0);
        checks++; if (false_start !== 1'b1) $display("FAIL false_level: got %0b, expected 1", false_start); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL false_busy: got %0b, expected 0", busy); else passes++;
        release_btn();
        // FALSE holds against time_out, ticks and presses.
        pulse_timeout();
        send_ticks(3);
        do_press(1'b0, 1'b0);
        release_btn();
        checks++; if (false_start !== 1'b1) $display("FAIL false_hold: got %0b, expected 1", false_start); else passes++;
        checks++; if (reaction_time !== 14'(m_reaction)) $display("FAIL false_reaction: got %0d, expected %0d", reaction_time, m_reaction); else passes++;
        checks++; if (valid_cnt !== v0) $display("FAIL false_valid: got %0d, expected %0d", valid_cnt, v0); else passes++;
        pulse_start();
        checks++; if (false_start !== 1'b0) $display("FAIL false_clear: got %0b, expected 0", false_start); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL false_restart_busy: got %0b, expected 1", busy); else passes++;
        finish_trial($urandom_range(200, 600), "after_false");
    endtask

    task automatic test_overflow();
        run_trial(MAX + 1, "overflow");
        run_trial(MAX, "exact_max");
    endtask

    task automatic test_simultaneous();
        int v0;
        v0 = valid_cnt;
        pulse_start();
        cyc(2);
        do_press(1'b0, 1'b1);
        checks++; if (false_start !== 1'b1) $display("FAIL coinc_timeout_false: got %0b, expected 1", false_start); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL coinc_timeout_busy: got %0b, expected 0", busy); else passes++;
        release_btn();
        checks++; if (valid_cnt !== v0) $display("FAIL coinc_timeout_valid: got %0d, expected %0d", valid_cnt, v0); else passes++;
        // A press and a tick on the same edge at count 5: the tick is dropped.
        pulse_start();
        cyc(1);
        pulse_timeout();
        send_ticks(5);
        do_press(1'b1, 1'b0);
        release_btn();
        m_reaction = 5; m_ovf = 0;
        if (5 < m_best) m_best = 5;
        checks++; if (reaction_time !== 14'd5) $display("FAIL coinc_tick_reaction: got %0d, expected 5", reaction_time); else passes++;
        checks++; if (best_time !== 14'(m_best)) $display("FAIL coinc_tick_best: got %0d, expected %0d", best_time, m_best); else passes++;
        checks++; if (valid_cnt - v0 !== 1) $display("FAIL coinc_tick_valid: got %0d, expected 1", valid_cnt - v0); else passes++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            cyc($urandom_range(0, 5));
            run_trial($urandom_range(0, 600), $sformatf("random%0d", i));
        end
    endtask

    task automatic test_restart_mid_timing();
        int v0;
        v0 = valid_cnt;
        pulse_start();
        pulse_timeout();
        send_ticks(50);
        pulse_start();
        checks++; if (busy !== 1'b1) $display("FAIL restart_busy: got %0b, expected 1", busy); else passes++;
        checks++; if (valid_cnt !== v0) $display("FAIL restart_valid: got %0d, expected %0d", valid_cnt, v0); else passes++;
        finish_trial($urandom_range(10, 90), "restart");
    endtask

    task automatic test_reset_abort();
        int v0;
        pulse_start();
        pulse_timeout();
        send_ticks(80);
        v0 = valid_cnt;
        #3 reset = 1'b1;
        #1;
        m_reaction = 0; m_best = MAX; m_ovf = 0;
        checks++; if (reaction_time !== 14'd0) $display("FAIL abort_reaction: got %0d, expected 0", reaction_time); else passes++;
        checks++; if (best_time !== 14'(MAX)) $display("FAIL abort_best: got %0d, expected %0d", best_time, MAX); else passes++;
        checks++; if ({valid, false_start, overflow, busy} !== 4'b0) $display("FAIL abort_flags: got %b, expected 0000", {valid, false_start, overflow, busy}); else passes++;
        react_trigger = 1'b1;
        cyc(3);
        reset = 1'b0;
        pulse_start();
        cyc(6);
        checks++; if (valid_cnt !== v0) $display("FAIL abort_valid: got %0d, expected %0d", valid_cnt, v0); else passes++;
        checks++; if (false_start !== 1'b0) $display("FAIL held_button_false: got %0b, expected 0", false_start); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL held_button_busy: got %0b, expected 1", busy); else passes++;
        release_btn();
        finish_trial(3, "repress");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_idle_ignore();
        test_normal();
        test_best();
        test_false_start();
        test_overflow();
        test_simultaneous();
        test_random();
        test_restart_mid_timing();
        test_reset_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
